i2c_slave_ctrl: RTL and testbench
=================================

Name: i2c_slave_ctrl

Overview:
- Control FSM for the I2C slave datapath.
- Sequences the SDA output selector (sda_mode), the RX/TX shift registers and the TX FIFO pop, from SCL edge pulses and start/stop detection.
- Performs the 7-bit address compare and the ACK/NACK handshakes.
- Sits between the edge/start-stop detectors and the sda selector, TX shift register and RX shift register.

Parameters:
SLAVE_ADDR, 7'b1111000, 7-bit slave address compared against rx_byte[7:1].

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous active-low reset
start_found  input  1  one-cycle pulse, START or repeated START detected
stop_found  input  1  one-cycle pulse, STOP detected
rising_edge_found  input  1  one-cycle pulse, SCL rising edge
falling_edge_found  input  1  one-cycle pulse, SCL falling edge
sda_in  input  1  synchronized SDA level (master ACK sample)
rx_byte  input  8  parallel RX shift register contents
tx_fifo_empty  input  1  TX FIFO has no data
sda_mode  output  2  00 idle/release(1), 01 ACK(0), 10 NACK(1), 11 drive tx_out
rx_enable  output  1  RX shift register samples on SCL rising edges
tx_enable  output  1  TX shift register shifts on SCL falling edges
load_data  output  1  one-cycle pulse, parallel-load TX shift register
read_enable  output  1  one-cycle pulse, pop TX FIFO (same cycle as load_data)
rx_write  output  1  one-cycle pulse, push rx_byte to RX FIFO
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs registered. On n_rst low at a clk edge: state IDLE, bit_cnt 0, sda_mode 00, all enables/pulses 0.
- Event priority, highest first: n_rst, stop_found, start_found, SCL edges.
  - stop_found in any state -> IDLE.
  - start_found in any state -> ADDR with bit_cnt cleared (repeated START included).
  - An edge pulse coincident with start/stop is ignored.
- bit_cnt: 4 bits. Counts rising edges in ADDR/RX and falling edges in TX. Cleared on every state entry. Saturates at 8.
- States and transitions:
  - IDLE: sda_mode 00. Leaves only on start_found.
  - ADDR: rx_enable 1, sda_mode 00. After the 8th rising edge -> ADDR_CHK.
  - ADDR_CHK: rx_enable 0. Waits for falling_edge_found, then:
    - rx_byte[7:1]==SLAVE_ADDR -> ACK_ADDR.
    - Otherwise -> WAIT_STOP with sda_mode 00.
  - ACK_ADDR: sda_mode 01, held until the next falling edge. Then:
    - rx_byte[0]==1 (read): -> LOAD.
    - rx_byte[0]==0 (write): -> RX.
  - LOAD: single cycle.
    - If !tx_fifo_empty: load_data=read_enable=1 -> TX.
    - If empty: sda_mode 10 -> WAIT_STOP.
  - TX: sda_mode 11, tx_enable 1. Bit 7 is valid from LOAD exit. After the 8th falling edge -> CHK_ACK.
  - CHK_ACK: sda_mode 00 (released). On rising edge, sample sda_in:
    - 0 (master ACK) -> ACK_WAIT.
    - 1 (NACK) -> WAIT_STOP.
  - ACK_WAIT: waits for falling edge -> LOAD (next byte).
  - RX: rx_enable 1, sda_mode 00. After the 8th rising edge -> RX_DONE.
  - RX_DONE: waits for falling edge. Then rx_write pulses for exactly 1 cycle -> ACK_DATA.
  - ACK_DATA: sda_mode 01 until the next falling edge -> RX.
  - WAIT_STOP: sda_mode 00, all enables 0. Leaves only on stop/start.
- Latency: each output changes on the clk edge after the qualifying pulse (1 cycle registered).
- sda_mode 01 is asserted for exactly one SCL low-high-low window.

Optional Feature:
- Macro GEN_CALL_EN.
- Defined: rx_byte==8'h00 in ADDR_CHK is also accepted (ACK_ADDR, then forced write path RX).
- Undefined: 8'h00 is treated as a mismatch -> WAIT_STOP, no ACK.

Decomposition:
- Package i2c_pkg holds:
  - state enum typedef (state_t, 4 bits).
  - sda_mode localparams: SDA_IDLE=2'b00, SDA_ACK=2'b01, SDA_NACK=2'b10, SDA_TX=2'b11.
  - BITS_PER_BYTE=8.
- One sub-module, i2c_bit_counter: clear, count-enable and done==8 flag, synchronous active-low reset.

Test Plan:
- Reset: n_rst=0 for 2 clk -> sda_mode=00, busy=0, all pulses 0. Then idle 20 clk with no edges -> unchanged.
- Write: START, address 0xF0 (0x78<<1|0), data 0xA5, STOP.
  - sda_mode=01 during each 9th SCL period.
  - rx_write pulses twice? No: exactly once, in the cycle after the falling edge following the 0xA5 byte.
  - busy drops on STOP.
- Read: START, address 0xF1, FIFO holds 0x3C/0x81, master ACKs byte 1 and NACKs byte 2.
  - load_data/read_enable pulse twice; sda_mode=11 for 8 bits each.
  - After the NACK -> WAIT_STOP, sda_mode=00.
- Mismatch: address 0x20 -> no 01 on sda_mode; WAIT_STOP until STOP; rx_write never pulses.
- Repeated START mid-TX (bit 3): -> ADDR with bit_cnt=0 and sda_mode=00 next cycle. Read with empty FIFO -> sda_mode=10, load_data stays 0.
- GEN_CALL_EN: address 0x00 acks (01) and enters RX when defined; no ACK when undefined. Also: stop_found coincident with rising_edge_found -> IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding, SDA selector codes and byte geometry
// for the I2C slave control path.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_CHK  = 4'd2,
        ACK_ADDR  = 4'd3,
        LOAD      = 4'd4,
        TX        = 4'd5,
        CHK_ACK   = 4'd6,
        ACK_WAIT  = 4'd7,
        RX        = 4'd8,
        RX_DONE   = 4'd9,
        ACK_DATA  = 4'd10,
        WAIT_STOP = 4'd11
    } state_t;

    localparam logic [1:0] SDA_IDLE = 2'b00;
    localparam logic [1:0] SDA_ACK  = 2'b01;
    localparam logic [1:0] SDA_NACK = 2'b10;
    localparam logic [1:0] SDA_TX   = 2'b11;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bit_counter.sv
// i2c_bit_counter: 4-bit SCL edge counter with synchronous clear that
// saturates at one full byte and flags when the byte is complete.
module i2c_bit_counter
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_clear,
    input  logic       i_count_en,
    output logic [3:0] o_count,
    output logic       o_done
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_count <= 4'd0;
        end else if (i_count_en && (r_count != BITS_PER_BYTE)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == BITS_PER_BYTE);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C slave control FSM (address compare, ACK/NACK, RX/TX sequencing).
// Build option: define GEN_CALL_EN to also acknowledge the general-call address 8'h00.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       sda_in,
    input  logic [7:0] rx_byte,
    input  logic       tx_fifo_empty,
    output logic [1:0] sda_mode,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       read_enable,
    output logic       rx_write,
    output logic       busy
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_sda_mode;
    logic [1:0] w_sda_next;
    logic       r_rx_enable;
    logic       r_tx_enable;
    logic       r_load_data;
    logic       r_rx_write;
    logic       r_busy;
    logic       w_load_next;
    logic       w_rx_write_next;
    logic       w_nack;
    logic       w_rise;
    logic       w_fall;
    logic       w_cnt_en;
    logic       w_clear;
    logic       w_last;
    logic       w_addr_match;
    logic [3:0] w_count;
    logic       w_done;

    // SCL edges lose to a coincident START/STOP.
    assign w_rise   = rising_edge_found && !start_found && !stop_found;
    assign w_fall   = falling_edge_found && !start_found && !stop_found;
    assign w_cnt_en = ((r_state == ADDR) || (r_state == RX)) ? w_rise :
                      (r_state == TX) ? w_fall : 1'b0;
    assign w_clear  = (w_next != r_state) || start_found || stop_found;
    assign w_last   = w_done || (w_cnt_en && (w_count == (BITS_PER_BYTE - 4'd1)));

`ifdef GEN_CALL_EN
    assign w_addr_match = (rx_byte[7:1] == SLAVE_ADDR) || (rx_byte == 8'h00);
`else
    assign w_addr_match = (rx_byte[7:1] == SLAVE_ADDR);
`endif

    i2c_bit_counter u_bit_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_clear),
        .i_count_en (w_cnt_en),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    always_comb begin
        w_next          = r_state;
        w_load_next     = 1'b0;
        w_rx_write_next = 1'b0;
        w_nack          = 1'b0;
        w_sda_next      = SDA_IDLE;
        if (stop_found) begin
            w_next = IDLE;
        end else if (start_found) begin
            w_next = ADDR;
        end else begin
            case (r_state)
                IDLE:      w_next = IDLE;
                ADDR:      if (w_last) w_next = ADDR_CHK;
                ADDR_CHK:  if (w_fall) w_next = w_addr_match ? ACK_ADDR : WAIT_STOP;
                // A general call carries R/W=0, so it naturally takes the write path.
                ACK_ADDR:  if (w_fall) w_next = rx_byte[0] ? LOAD : RX;
                LOAD: begin
                    if (!tx_fifo_empty) begin
                        w_next      = TX;
                        w_load_next = 1'b1;
                    end else begin
                        w_next = WAIT_STOP;
                        w_nack = 1'b1;
                    end
                end
                TX:        if (w_last) w_next = CHK_ACK;
                CHK_ACK:   if (w_rise) w_next = sda_in ? WAIT_STOP : ACK_WAIT;
                ACK_WAIT:  if (w_fall) w_next = LOAD;
                RX:        if (w_last) w_next = RX_DONE;
                RX_DONE: begin
                    if (w_fall) begin
                        w_next          = ACK_DATA;
                        w_rx_write_next = 1'b1;
                    end
                end
                ACK_DATA:  if (w_fall) w_next = RX;
                // A NACK raised on an empty FIFO is held for one SCL window.
                WAIT_STOP: w_nack = (r_sda_mode == SDA_NACK) && !w_fall;
                default:   w_next = IDLE;
            endcase
        end
        case (w_next)
            ACK_ADDR, ACK_DATA: w_sda_next = SDA_ACK;
            TX:                 w_sda_next = SDA_TX;
            default:            w_sda_next = SDA_IDLE;
        endcase
        if (w_nack) begin
            w_sda_next = SDA_NACK;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_sda_mode  <= SDA_IDLE;
            r_rx_enable <= 1'b0;
            r_tx_enable <= 1'b0;
            r_load_data <= 1'b0;
            r_rx_write  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sda_mode  <= w_sda_next;
            r_rx_enable <= (w_next == ADDR) || (w_next == RX);
            r_tx_enable <= (w_next == TX);
            r_load_data <= w_load_next;
            r_rx_write  <= w_rx_write_next;
            r_busy      <= (w_next != IDLE);
        end
    end

    assign sda_mode    = r_sda_mode;
    assign rx_enable   = r_rx_enable;
    assign tx_enable   = r_tx_enable;
    assign load_data   = r_load_data;
    assign read_enable = r_load_data;
    assign rx_write    = r_rx_write;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: directed, table-driven bench for i2c_slave_ctrl.
// Expectations for the general-call address follow the GEN_CALL_EN macro.
module tb_i2c_slave_ctrl;

    // Packed expected output: {sda_mode, rx_enable, tx_enable, load_data, read_enable, rx_write, busy}
    localparam logic [7:0] O_IDLE = 8'b00_0_0_0_0_0_0;
    localparam logic [7:0] O_ADDR = 8'b00_1_0_0_0_0_1;
    localparam logic [7:0] O_CHK  = 8'b00_0_0_0_0_0_1;
    localparam logic [7:0] O_ACK  = 8'b01_0_0_0_0_0_1;
    localparam logic [7:0] O_ACKW = 8'b01_0_0_0_0_1_1;
    localparam logic [7:0] O_TXL  = 8'b11_0_1_1_1_0_1;
    localparam logic [7:0] O_TX   = 8'b11_0_1_0_0_0_1;
    localparam logic [7:0] O_NACK = 8'b10_0_0_0_0_0_1;

`ifdef GEN_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       rise;
        logic       fall;
        logic [7:0] rxByte;
        logic [7:0] expOut;
    } vec_t;

    logic       clk;
    logic       nRst;
    logic       startFound;
    logic       stopFound;
    logic       riseFound;
    logic       fallFound;
    logic       sdaIn;
    logic [7:0] rxByte;
    logic       fifoEmpty;
    logic [1:0] sdaMode;
    logic       rxEnable;
    logic       txEnable;
    logic       loadData;
    logic       readEnable;
    logic       rxWrite;
    logic       busy;

    int   total;
    int   bad;
    int   loadSeen;
    int   rxWriteSeen;
    int   snapLoad;
    int   snapWrite;
    vec_t vecs[$];

    i2c_slave_ctrl dut (
        .clk                (clk),
        .n_rst              (nRst),
        .start_found        (startFound),
        .stop_found         (stopFound),
        .rising_edge_found  (riseFound),
        .falling_edge_found (fallFound),
        .sda_in             (sdaIn),
        .rx_byte            (rxByte),
        .tx_fifo_empty      (fifoEmpty),
        .sda_mode           (sdaMode),
        .rx_enable          (rxEnable),
        .tx_enable          (txEnable),
        .load_data          (loadData),
        .read_enable        (readEnable),
        .rx_write           (rxWrite),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle so each one-cycle pulse counts once.
    initial begin
        loadSeen    = 0;
        rxWriteSeen = 0;
    end
    always @(negedge clk) begin
        if (loadData === 1'b1) loadSeen = loadSeen + 1;
        if (rxWrite === 1'b1) rxWriteSeen = rxWriteSeen + 1;
    end

    task automatic applyStimulus(input logic st, input logic sp, input logic r, input logic f);
        startFound = st;
        stopFound  = sp;
        riseFound  = r;
        fallFound  = f;
        @(posedge clk);
        #1;
        startFound = 1'b0;
        stopFound  = 1'b0;
        riseFound  = 1'b0;
        fallFound  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expOut);
        logic [7:0] actual;
        actual = {sdaMode, rxEnable, txEnable, loadData, readEnable, rxWrite, busy};
        total = total + 1;
        if (actual !== expOut) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, actual, expOut, $time);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input logic st, input logic sp, input logic r, input logic f,
                        input string name, input logic [7:0] expOut);
        applyStimulus(st, sp, r, f);
        checkOutput(name, expOut);
    endtask

    task automatic addVec(input logic st, input logic sp, input logic r, input logic f,
                          input logic [7:0] rb, input logic [7:0] expOut);
        vec_t v;
        v.start  = st;
        v.stop   = sp;
        v.rise   = r;
        v.fall   = f;
        v.rxByte = rb;
        v.expOut = expOut;
        vecs.push_back(v);
    endtask

    // START, ignored first SCL fall, then 8 address bits; expLast follows the 9th-bit fall.
    task automatic addAddrVecs(input logic [7:0] addr, input logic [7:0] expLast);
        addVec(1, 0, 0, 0, addr, O_ADDR);
        addVec(0, 0, 0, 1, addr, O_ADDR);
        for (int i = 0; i < 8; i++) begin
            addVec(0, 0, 1, 0, addr, (i < 7) ? O_ADDR : O_CHK);
            addVec(0, 0, 0, 1, addr, (i < 7) ? O_ADDR : expLast);
        end
    endtask

    task automatic sendAddr(input logic [7:0] addr, input logic [7:0] expLast);
        rxByte = addr;
        step(1, 0, 0, 0, "seqStart", O_ADDR);
        step(0, 0, 0, 1, "seqAddrFall0", O_ADDR);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, "seqAddrRise", (i < 7) ? O_ADDR : O_CHK);
            step(0, 0, 0, 1, "seqAddrFall", (i < 7) ? O_ADDR : expLast);
        end
    endtask

    task automatic txByte(input int nFalls, input logic [7:0] expLast);
        for (int i = 0; i < nFalls; i++) begin
            step(0, 0, 1, 0, "txRise", O_TX);
            step(0, 0, 0, 1, "txFall", (i < 7) ? O_TX : expLast);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        nRst       = 1'b0;
        startFound = 1'b0;
        stopFound  = 1'b0;
        riseFound  = 1'b0;
        fallFound  = 1'b0;
        sdaIn      = 1'b1;
        rxByte     = 8'h00;
        fifoEmpty  = 1'b1;

        // Reset and quiet idle
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", O_IDLE);
        nRst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, "idleNoEdges", O_IDLE);
        end

        // Table: write transaction, coincident events, mismatch, general call
        addVec(0, 0, 0, 0, 8'hF0, O_IDLE);
        addAddrVecs(8'hF0, O_ACK);
        addVec(0, 0, 1, 0, 8'hF0, O_ACK);
        addVec(0, 0, 0, 1, 8'hF0, O_ADDR);
        for (int i = 0; i < 8; i++) begin
            addVec(0, 0, 1, 0, 8'hA5, (i < 7) ? O_ADDR : O_CHK);
            addVec(0, 0, 0, 1, 8'hA5, (i < 7) ? O_ADDR : O_ACKW);
        end
        addVec(0, 0, 0, 0, 8'hA5, O_ACK);
        addVec(0, 0, 1, 0, 8'hA5, O_ACK);
        addVec(0, 0, 0, 1, 8'hA5, O_ADDR);
        addVec(0, 1, 0, 0, 8'hA5, O_IDLE);
        addVec(0, 0, 0, 0, 8'hA5, O_IDLE);
        addVec(1, 0, 0, 0, 8'h00, O_ADDR);
        addVec(0, 0, 1, 0, 8'h00, O_ADDR);
        addVec(0, 1, 1, 0, 8'h00, O_IDLE);
        addVec(1, 0, 1, 0, 8'h00, O_ADDR);
        for (int i = 0; i < 8; i++) begin
            addVec(0, 0, 1, 0, 8'h00, (i < 7) ? O_ADDR : O_CHK);
        end
        addVec(0, 1, 0, 0, 8'h00, O_IDLE);
        addAddrVecs(8'h20, O_CHK);
        addVec(0, 0, 1, 0, 8'h20, O_CHK);
        addVec(0, 0, 0, 1, 8'h20, O_CHK);
        addVec(0, 0, 1, 0, 8'h20, O_CHK);
        addVec(0, 0, 0, 1, 8'h20, O_CHK);
        addVec(0, 1, 0, 0, 8'h20, O_IDLE);
        addAddrVecs(8'h00, GC ? O_ACK : O_CHK);
        addVec(0, 0, 1, 0, 8'h00, GC ? O_ACK : O_CHK);
        addVec(0, 0, 0, 1, 8'h00, GC ? O_ADDR : O_CHK);
        addVec(0, 1, 0, 0, 8'h00, O_IDLE);

        snapWrite = rxWriteSeen;
        for (int i = 0; i < vecs.size(); i++) begin
            rxByte = vecs[i].rxByte;
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].rise, vecs[i].fall);
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
        end
        checkCount("rxWriteCountTable", rxWriteSeen - snapWrite, 1);

        // Read: master ACKs first byte, NACKs second
        snapLoad  = loadSeen;
        fifoEmpty = 1'b0;
        sdaIn     = 1'b1;
        sendAddr(8'hF1, O_ACK);
        step(0, 0, 1, 0, "rdAckRise", O_ACK);
        step(0, 0, 0, 1, "rdAckFall", O_CHK);
        step(0, 0, 0, 0, "rdLoad1", O_TXL);
        step(0, 0, 0, 0, "rdTx1", O_TX);
        txByte(8, O_CHK);
        sdaIn = 1'b0;
        step(0, 0, 1, 0, "rdMasterAck", O_CHK);
        step(0, 0, 0, 1, "rdAckWaitFall", O_CHK);
        step(0, 0, 0, 0, "rdLoad2", O_TXL);
        step(0, 0, 0, 0, "rdTx2", O_TX);
        txByte(8, O_CHK);
        sdaIn = 1'b1;
        step(0, 0, 1, 0, "rdMasterNack", O_CHK);
        step(0, 0, 0, 1, "rdWaitStopFall", O_CHK);
        step(0, 0, 0, 0, "rdWaitStopIdle", O_CHK);
        step(0, 1, 0, 0, "rdStop", O_IDLE);
        checkCount("loadCountRead", loadSeen - snapLoad, 2);

        // Repeated START at bit 3 of TX, then read with an empty FIFO
        snapLoad = loadSeen;
        sendAddr(8'hF1, O_ACK);
        step(0, 0, 1, 0, "rsAckRise", O_ACK);
        step(0, 0, 0, 1, "rsAckFall", O_CHK);
        step(0, 0, 0, 0, "rsLoad", O_TXL);
        step(0, 0, 0, 0, "rsTx", O_TX);
        txByte(3, O_TX);
        step(1, 0, 0, 1, "rsRepStart", O_ADDR);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, "rsAddrRise", (i < 7) ? O_ADDR : O_CHK);
            step(0, 0, 0, 1, "rsAddrFall", (i < 7) ? O_ADDR : O_ACK);
        end
        step(0, 0, 1, 0, "rsAckRise2", O_ACK);
        fifoEmpty = 1'b1;
        step(0, 0, 0, 1, "emptyLoad", O_CHK);
        step(0, 0, 0, 0, "emptyNack", O_NACK);
        step(0, 0, 0, 0, "emptyNackHold", O_NACK);
        step(0, 0, 1, 0, "emptyNackRise", O_NACK);
        step(0, 0, 0, 1, "emptyNackRelease", O_CHK);
        step(0, 1, 0, 0, "emptyStop", O_IDLE);
        checkCount("loadCountRepStart", loadSeen - snapLoad, 1);

        // Reset in the middle of an address phase
        step(1, 0, 0, 0, "midStart", O_ADDR);
        step(0, 0, 1, 0, "midRise", O_ADDR);
        nRst = 1'b0;
        step(0, 0, 1, 0, "midReset", O_IDLE);
        nRst = 1'b1;
        step(0, 0, 0, 0, "postReset", O_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
